// File: rtl/imm_ext_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// imm_ext_arbiter_pkg
// Shared definitions for the immediate-extend arbiter:
//   - TAG_W_DEF          : default tag width
//   - REQ_DEC / REQ_BR   : requester id constants (decode, branch unit)
//   - PFX_POW / PFX_MASK : 5-bit immediate prefixes selecting the
//                          power-of-two and low-mask encodings
//   - imm_ext()          : the 8-to-16-bit immediate extend unit
//   - sat_inc16()        : saturating 16-bit increment (statistics)
// ----------------------------------------------------------------------------
package imm_ext_arbiter_pkg;

  localparam int TAG_W_DEF = 4;

  localparam logic REQ_DEC = 1'b0;
  localparam logic REQ_BR  = 1'b1;

  localparam logic [4:0] PFX_POW  = 5'b10000;
  localparam logic [4:0] PFX_MASK = 5'b10001;

  // Both special prefixes sit inside the negative range. They take priority
  // over plain sign extension.
  function automatic logic [15:0] imm_ext(input logic [7:0] a);
    logic [4:0] sh;
    sh = {2'b00, a[2:0]};
    case (a[7:3])
      PFX_POW:  imm_ext = 16'd1 << (5'd7 + sh);
      PFX_MASK: imm_ext = (16'd1 << (5'd8 + sh)) - 16'd1;
      default:  imm_ext = {{8{a[7]}}, a};
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/imm_ext_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin pick.
//   i_valid   [1:0] request valid bits
//   i_rr_last       id of the most recent winner
//   o_grant   [1:0] one-hot grant (all zero when nothing is valid)
//   o_id            id of the granted requester
// ----------------------------------------------------------------------------
module rr_arb2
  import imm_ext_arbiter_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_rr_last,
  output logic [1:0] o_grant,
  output logic       o_id
);

  always_comb begin
    o_grant = 2'b00;
    o_id    = REQ_DEC;
    case (i_valid)
      2'b01: begin
        o_grant = 2'b01;
        o_id    = REQ_DEC;
      end
      2'b10: begin
        o_grant = 2'b10;
        o_id    = REQ_BR;
      end
      2'b11: begin
        // Contention: the requester that did not win last time goes next.
        o_id    = ~i_rr_last;
        o_grant = i_rr_last ? 2'b01 : 2'b10;
      end
      default: begin
        o_grant = 2'b00;
        o_id    = REQ_DEC;
      end
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// ----------------------------------------------------------------------------
// imm_ext_arbiter
// Shares the 8-to-16-bit immediate extend unit between decode (port 0) and
// the branch-target unit (port 1) with round-robin arbitration and a single
// registered result stage.
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (bit 0 decode, bit 1 branch)
//   req_imm0/1, req_tag0/1 raw immediates and opaque tags
//   res_valid/res_ready   result handshake toward the consumer
//   res_data/res_id/res_tag extended value, winning requester, its tag
// Optional build macro IMM_ARB_STATS_EN adds saturating counters
//   grant_cnt0, grant_cnt1 (transfers per requester) and stall_cnt
//   (cycles with a pending request while the stage is blocked).
// ----------------------------------------------------------------------------
module imm_ext_arbiter
  import imm_ext_arbiter_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int ID_W  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [7:0]       req_imm0,
  input  logic [7:0]       req_imm1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic [ID_W-1:0]  res_id,
  output logic [TAG_W-1:0] res_tag
`ifdef IMM_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1,
  output logic [15:0]      stall_cnt
`endif
);

  logic             r_valid;
  logic [15:0]      r_data;
  logic [ID_W-1:0]  r_id;
  logic [TAG_W-1:0] r_tag;
  logic             r_rr_last;

  logic             w_open;
  logic [1:0]       w_grant;
  logic             w_id;
  logic             w_xfer;
  logic [7:0]       w_imm;
  logic [15:0]      w_ext;

  rr_arb2 u_rr_arb2 (
    .i_valid   (req_valid),
    .i_rr_last (r_rr_last),
    .o_grant   (w_grant),
    .o_id      (w_id)
  );

  // Drain and refill may coincide, so a ready consumer also opens the stage.
  assign w_open    = !r_valid || res_ready;
  assign req_ready = (w_open && !reset) ? w_grant : 2'b00;
  assign w_xfer    = |(req_valid & req_ready);
  assign w_imm     = w_id ? req_imm1 : req_imm0;
  assign w_ext     = imm_ext(w_imm);

  // Result stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_data    <= 16'd0;
      r_id      <= '0;
      r_tag     <= '0;
      r_rr_last <= REQ_BR;
    end else if (w_xfer) begin
      r_valid   <= 1'b1;
      r_data    <= w_ext;
      r_id      <= ID_W'(w_id);
      r_tag     <= w_id ? req_tag1 : req_tag0;
      r_rr_last <= w_id;
    end else if (w_open) begin
      r_valid   <= 1'b0;
    end
  end

  assign res_valid = r_valid;
  assign res_data  = r_data;
  assign res_id    = r_id;
  assign res_tag   = r_tag;

`ifdef IMM_ARB_STATS_EN
  logic [15:0] r_gcnt0;
  logic [15:0] r_gcnt1;
  logic [15:0] r_scnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gcnt0 <= 16'd0;
      r_gcnt1 <= 16'd0;
      r_scnt  <= 16'd0;
    end else begin
      if (w_xfer && (w_id == REQ_DEC)) r_gcnt0 <= sat_inc16(r_gcnt0);
      if (w_xfer && (w_id == REQ_BR))  r_gcnt1 <= sat_inc16(r_gcnt1);
      if ((|req_valid) && !w_open)     r_scnt  <= sat_inc16(r_scnt);
    end
  end

  assign grant_cnt0 = r_gcnt0;
  assign grant_cnt1 = r_gcnt1;
  assign stall_cnt  = r_scnt;
`endif

endmodule

// File: tb/tb_imm_ext_arbiter.sv
module tb_imm_ext_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_imm0;
  logic [7:0]  req_imm1;
  logic [3:0]  req_tag0;
  logic [3:0]  req_tag1;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [0:0]  res_id;
  logic [3:0]  res_tag;
`ifdef IMM_ARB_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
  logic [15:0] stall_cnt;
`endif

  imm_ext_arbiter #(.TAG_W(4), .ID_W(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_imm0  (req_imm0),
    .req_imm1  (req_imm1),
    .req_tag0  (req_tag0),
    .req_tag1  (req_tag1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_tag   (res_tag)
`ifdef IMM_ARB_STATS_EN
    ,
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  rv;
    logic [7:0]  i0;
    logic [7:0]  i1;
    logic [3:0]  t0;
    logic [3:0]  t1;
    logic        rr;
    logic [1:0]  rdy;   // expected req_ready before the edge
    logic        vld;   // expected outputs after the edge
    logic [15:0] d;
    logic        id;
    logic [3:0]  tag;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rv, input logic [7:0] i0, input logic [7:0] i1,
                       input logic [3:0] t0, input logic [3:0] t1, input logic rr);
    req_valid = rv;
    req_imm0  = i0;
    req_imm1  = i1;
    req_tag0  = t0;
    req_tag1  = t1;
    res_ready = rr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Sequential table: expectations depend on the round-robin history.
    vec[0]  = '{2'b01, 8'h85, 8'h00, 4'd3, 4'd0, 1'b1, 2'b01, 1'b1, 16'h1000, 1'b0, 4'd3};
    vec[1]  = '{2'b10, 8'h00, 8'h8F, 4'd0, 4'd5, 1'b1, 2'b10, 1'b1, 16'h7FFF, 1'b1, 4'd5};
    vec[2]  = '{2'b10, 8'h00, 8'hF0, 4'd0, 4'd6, 1'b1, 2'b10, 1'b1, 16'hFFF0, 1'b1, 4'd6};
    vec[3]  = '{2'b11, 8'h7F, 8'h80, 4'd1, 4'd2, 1'b1, 2'b01, 1'b1, 16'h007F, 1'b0, 4'd1};
    vec[4]  = '{2'b11, 8'h01, 8'h80, 4'd4, 4'd2, 1'b1, 2'b10, 1'b1, 16'h0080, 1'b1, 4'd2};
    vec[5]  = '{2'b11, 8'h88, 8'h87, 4'd7, 4'd8, 1'b1, 2'b01, 1'b1, 16'h00FF, 1'b0, 4'd7};
    vec[6]  = '{2'b11, 8'h88, 8'h87, 4'd7, 4'd8, 1'b1, 2'b10, 1'b1, 16'h4000, 1'b1, 4'd8};
    vec[7]  = '{2'b00, 8'h00, 8'h00, 4'd0, 4'd0, 1'b1, 2'b00, 1'b0, 16'h0000, 1'b0, 4'd0};
    vec[8]  = '{2'b11, 8'h90, 8'h08, 4'd9, 4'd10, 1'b1, 2'b01, 1'b1, 16'hFF90, 1'b0, 4'd9};
    vec[9]  = '{2'b11, 8'h90, 8'h08, 4'd9, 4'd10, 1'b0, 2'b00, 1'b1, 16'hFF90, 1'b0, 4'd9};
    vec[10] = '{2'b11, 8'h90, 8'h08, 4'd9, 4'd10, 1'b0, 2'b00, 1'b1, 16'hFF90, 1'b0, 4'd9};
    vec[11] = '{2'b11, 8'h90, 8'h08, 4'd9, 4'd10, 1'b0, 2'b00, 1'b1, 16'hFF90, 1'b0, 4'd9};
    vec[12] = '{2'b11, 8'h90, 8'h08, 4'd9, 4'd10, 1'b1, 2'b10, 1'b1, 16'h0008, 1'b1, 4'd10};
    vec[13] = '{2'b11, 8'h90, 8'h08, 4'd9, 4'd10, 1'b1, 2'b01, 1'b1, 16'hFF90, 1'b0, 4'd9};

    // Reset state
    reset = 1'b1;
    drive(2'b11, 8'h00, 8'h00, 4'd0, 4'd0, 1'b1);
    tick;
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    tick;
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_data",  {16'd0, res_data}, 32'd0);
    chk("rst_id",    {31'd0, res_id}, 32'd0);
    chk("rst_tag",   {28'd0, res_tag}, 32'd0);
    reset = 1'b0;
    drive(2'b00, 8'h00, 8'h00, 4'd0, 4'd0, 1'b1);
    tick;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      drive(vec[i].rv, vec[i].i0, vec[i].i1, vec[i].t0, vec[i].t1, vec[i].rr);
      #2;
      chk($sformatf("v%0d_ready", i), {30'd0, req_ready}, {30'd0, vec[i].rdy});
      tick;
      chk($sformatf("v%0d_valid", i), {31'd0, res_valid}, {31'd0, vec[i].vld});
      if (vec[i].vld) begin
        chk($sformatf("v%0d_data", i), {16'd0, res_data}, {16'd0, vec[i].d});
        chk($sformatf("v%0d_id", i),   {31'd0, res_id},   {31'd0, vec[i].id});
        chk($sformatf("v%0d_tag", i),  {28'd0, res_tag},  {28'd0, vec[i].tag});
      end
    end

    // Mid-operation reset: the held result disappears without a clock edge.
    chk("pre_rst_valid", {31'd0, res_valid}, 32'd1);
    drive(2'b11, 8'h90, 8'h08, 4'd9, 4'd10, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, res_valid}, 32'd0);
    chk("async_rst_ready", {30'd0, req_ready}, 32'd0);
    #1;
    reset = 1'b0;
    drive(2'b11, 8'h81, 8'h08, 4'd2, 4'd10, 1'b1);
    #1;
    chk("post_rst_ready", {30'd0, req_ready}, 32'd1);
    tick;
    chk("post_rst_valid", {31'd0, res_valid}, 32'd1);
    chk("post_rst_id",    {31'd0, res_id}, 32'd0);
    chk("post_rst_data",  {16'd0, res_data}, 32'h0100);
    chk("post_rst_tag",   {28'd0, res_tag}, 32'd2);
    // Continued contention alternates to requester 1.
    tick;
    chk("alt_id", {31'd0, res_id}, 32'd1);
    chk("alt_data", {16'd0, res_data}, 32'h0008);

`ifdef IMM_ARB_STATS_EN
    // Statistics: 5 grants to decode, 3 to branch, 2 stalled cycles.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 8'h01, 8'h02, 4'd1, 4'd2, 1'b1);
      tick;
    end
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 8'h01, 8'h02, 4'd1, 4'd2, 1'b1);
      tick;
    end
    drive(2'b01, 8'h01, 8'h02, 4'd1, 4'd2, 1'b1);
    tick;
    for (int k = 0; k < 2; k++) begin
      drive(2'b01, 8'h01, 8'h02, 4'd1, 4'd2, 1'b0);
      tick;
    end
    drive(2'b00, 8'h01, 8'h02, 4'd1, 4'd2, 1'b1);
    tick;
    chk("grant_cnt0", {16'd0, grant_cnt0}, 32'd5);
    chk("grant_cnt1", {16'd0, grant_cnt1}, 32'd3);
    chk("stall_cnt",  {16'd0, stall_cnt},  32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
